// File: rtl/icg_pkg.sv
// Shared types for the multi-channel clock gate controller.
package icg_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    PEND  = 2'd1,
    ON    = 2'd2,
    DRAIN = 2'd3
  } icg_state_t;

  // A wake budget that covers every channel disables the limiter entirely.
  function automatic logic is_unlimited(input int wake_max, input int n_ch);
    return wake_max >= n_ch;
  endfunction

endpackage

// File: rtl/icg_chan.sv
// One gated clock channel: request FSM with hysteresis counter, low-transparent
// enable latch and output AND gate.
module icg_chan
  import icg_pkg::*;
#(
  parameter int HOLD_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              te_i,
  input  logic              e_i,
  input  logic              grant_i,
  input  logic [HOLD_W-1:0] hold_i,
  output logic              cand_o,
  output logic              rdy_o,
  output logic              q_o
);

  icg_state_t        state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              en_lat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      OFF: begin
        if (e_i && grant_i)  state_d = ON;
        else if (e_i)        state_d = PEND;
      end
      PEND: begin
        if (grant_i) state_d = ON;
      end
      ON: begin
        if (!e_i) begin
          if (hold_i == '0) begin
            state_d = OFF;
          end else begin
            state_d = DRAIN;
            cnt_d   = hold_i;
          end
        end
      end
      DRAIN: begin
        if (e_i) begin
          state_d = ON;
        end else if (cnt_q <= HOLD_W'(1)) begin
          state_d = OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = OFF;
    endcase
  end

  assign rdy_d  = (state_d == ON) || (state_d == DRAIN);
  assign cand_o = (state_q == PEND) || ((state_q == OFF) && e_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OFF;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  // Enable only moves while the clock is low, so Q can never be chopped mid-pulse.
  always_latch begin
    if (!rst_ni)     en_lat <= 1'b0;
    else if (!clk_i) en_lat <= rdy_q;
  end

  assign rdy_o = rdy_q;
  assign q_o   = clk_i & (en_lat | te_i);

endmodule

// File: rtl/icg_multi_hyst_ctrl.sv
// Multi-channel clock gate controller: per-channel gates plus a fixed-priority
// wake-up limiter bounding simultaneous clock turn-ons.
module icg_multi_hyst_ctrl
  import icg_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int HOLD_W   = 4,
  parameter int WAKE_MAX = 1
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              TE,
  input  logic [N_CH-1:0]   E,
  input  logic [HOLD_W-1:0] HOLD,
  output logic [N_CH-1:0]   Q,
  output logic [N_CH-1:0]   RDY,
  inout  wire               VDD,
  inout  wire               VSS
);

  localparam logic UNLIM = is_unlimited(WAKE_MAX, N_CH);

  logic [N_CH-1:0] cand;
  logic [N_CH-1:0] grant;
  logic            unused_supply;

  assign unused_supply = VDD ^ VSS;

  // Lowest index wins; the running count of earlier candidates caps the grants.
  always_comb begin
    int n_granted;
    grant     = '0;
    n_granted = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (cand[i] && (UNLIM || (n_granted < WAKE_MAX))) begin
        grant[i]  = 1'b1;
        n_granted = n_granted + 1;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    icg_chan #(
      .HOLD_W(HOLD_W)
    ) u_chan (
      .clk_i  (CLK),
      .rst_ni (RN),
      .te_i   (TE),
      .e_i    (E[g]),
      .grant_i(grant[g]),
      .hold_i (HOLD),
      .cand_o (cand[g]),
      .rdy_o  (RDY[g]),
      .q_o    (Q[g])
    );
  end

endmodule

// File: tb/tb_icg_multi_hyst_ctrl.sv
// Self-checking bench: directed vector table, async reset / test-enable sequences,
// and randomized traffic against a cycle-count reference model.
module tb_icg_multi_hyst_ctrl;

  localparam int NC = 4;
  localparam int HW = 4;
  localparam int WM = 1;

  logic          clk;
  logic          rn;
  logic          te;
  logic [NC-1:0] e;
  logic [HW-1:0] hold;
  logic [NC-1:0] q;
  logic [NC-1:0] rdy;
  wire           vdd = 1'b1;
  wire           vss = 1'b0;

  icg_multi_hyst_ctrl #(
    .N_CH(NC), .HOLD_W(HW), .WAKE_MAX(WM)
  ) dut (
    .CLK (clk),
    .RN  (rn),
    .TE  (te),
    .E   (e),
    .HOLD(hold),
    .Q   (q),
    .RDY (rdy),
    .VDD (vdd),
    .VSS (vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [NC-1:0] e;
    logic [HW-1:0] hold;
    logic [NC-1:0] rdy;
    logic [NC-1:0] q;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [NC-1:0] ve, input logic [HW-1:0] vh,
                     input logic [NC-1:0] vr, input logic [NC-1:0] vq);
    vec_t v;
    v.e = ve; v.hold = vh; v.rdy = vr; v.q = vq;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs in the low phase, then sample just after the next rising edge.
  task automatic cycle(input logic [NC-1:0] ve, input logic [HW-1:0] vh, input logic vte,
                       output logic [NC-1:0] r, output logic [NC-1:0] qq);
    @(negedge clk);
    e = ve; hold = vh; te = vte;
    @(posedge clk);
    #1;
    r  = rdy;
    qq = q;
  endtask

  // Reference model: a channel is enabled once granted and stays enabled until
  // E has been low for more than the HOLD value captured when it fell.
  bit          m_en  [NC];
  bit          m_pend[NC];
  int          m_lc  [NC];
  int          m_cap [NC];

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin
      m_en[i] = 0; m_pend[i] = 0; m_lc[i] = 0; m_cap[i] = 0;
    end
  endfunction

  function automatic logic [NC-1:0] model_step(input logic [NC-1:0] ve, input int vh);
    int budget;
    logic [NC-1:0] r;
    budget = WM;
    r = '0;
    for (int i = 0; i < NC; i++) begin
      if (m_en[i]) begin
        if (ve[i]) begin
          m_lc[i] = 0;
        end else begin
          m_lc[i] = m_lc[i] + 1;
          if (m_lc[i] == 1) m_cap[i] = vh;
          if (m_lc[i] > m_cap[i]) m_en[i] = 0;
        end
      end else if (m_pend[i] || ve[i]) begin
        if (budget > 0) begin
          budget--;
          m_en[i] = 1; m_pend[i] = 0; m_lc[i] = 0;
        end else begin
          m_pend[i] = 1;
        end
      end
      r[i] = m_en[i];
    end
    return r;
  endfunction

  logic [NC-1:0] r_act, q_act, exp_r, prev_r, ve;
  logic [HW-1:0] vh;
  logic          vte;

  initial begin
    rn = 1'b0; te = 1'b0; e = '0; hold = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy", rdy, '0);
    check("reset_q", q, '0);
    @(negedge clk);
    rn = 1'b1;

    // Async reset in the middle of a drain, while the clock is high.
    cycle(4'b0001, 4'd3, 1'b0, r_act, q_act);
    cycle(4'b0001, 4'd3, 1'b0, r_act, q_act);
    cycle(4'b0000, 4'd3, 1'b0, r_act, q_act);
    check("drain_rdy", r_act, 4'b0001);
    check("drain_q", q_act, 4'b0001);
    #2;
    rn = 1'b0;
    #1;
    check("async_rst_rdy", rdy, '0);
    check("async_rst_q", q, '0);

    // Test enable forces clocks through while held in reset.
    te = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("te_q_high", q, 4'b1111);
      check("te_rdy", rdy, '0);
      @(negedge clk); #1;
      check("te_q_low", q, '0);
    end
    te = 1'b0;
    @(negedge clk);
    rn = 1'b1;

    // Hysteresis HOLD=3: 5 request cycles give 8 enabled cycles.
    for (int k = 0; k < 5; k++) add(4'b0001, 4'd3, 4'b0001, (k == 0) ? 4'b0000 : 4'b0001);
    add(4'b0000, 4'd3, 4'b0001, 4'b0001);
    add(4'b0000, 4'd3, 4'b0001, 4'b0001);
    add(4'b0000, 4'd3, 4'b0001, 4'b0001);
    add(4'b0000, 4'd3, 4'b0000, 4'b0001);
    add(4'b0000, 4'd3, 4'b0000, 4'b0000);
    // HOLD=0 single-cycle pulse.
    add(4'b0010, 4'd0, 4'b0010, 4'b0000);
    add(4'b0000, 4'd0, 4'b0000, 4'b0010);
    add(4'b0000, 4'd0, 4'b0000, 4'b0000);
    // Wake limit: one channel per cycle, index order.
    add(4'b1111, 4'd0, 4'b0001, 4'b0000);
    add(4'b1111, 4'd0, 4'b0011, 4'b0001);
    add(4'b1111, 4'd0, 4'b0111, 4'b0011);
    add(4'b1111, 4'd0, 4'b1111, 4'b0111);
    add(4'b1111, 4'd0, 4'b1111, 4'b1111);
    add(4'b0000, 4'd0, 4'b0000, 4'b1111);
    add(4'b0000, 4'd0, 4'b0000, 4'b0000);
    // Re-request during drain (HOLD=4) keeps the clock running without a new grant.
    add(4'b0100, 4'd4, 4'b0100, 4'b0000);
    add(4'b0100, 4'd4, 4'b0100, 4'b0100);
    add(4'b0000, 4'd4, 4'b0100, 4'b0100);
    add(4'b0000, 4'd4, 4'b0100, 4'b0100);
    add(4'b0100, 4'd4, 4'b0100, 4'b0100);
    for (int k = 0; k < 4; k++) add(4'b0000, 4'd4, 4'b0100, 4'b0100);
    add(4'b0000, 4'd4, 4'b0000, 4'b0100);
    add(4'b0000, 4'd4, 4'b0000, 4'b0000);

    foreach (tbl[i]) begin
      cycle(tbl[i].e, tbl[i].hold, 1'b0, r_act, q_act);
      check($sformatf("vec%0d_rdy", i), r_act, tbl[i].rdy);
      check($sformatf("vec%0d_q", i), q_act, tbl[i].q);
    end

    // Randomized traffic from a fresh reset.
    @(negedge clk);
    rn = 1'b0;
    @(negedge clk);
    rn = 1'b1;
    model_reset();
    prev_r = '0;
    ve = '0;
    for (int k = 0; k < 400; k++) begin
      ve  = ve ^ (NC'($urandom_range(0, 15)) & NC'($urandom_range(0, 15)));
      vh  = HW'($urandom_range(0, 5));
      vte = ($urandom_range(0, 7) == 0);
      exp_r = model_step(ve, int'(vh));
      cycle(ve, vh, vte, r_act, q_act);
      check("rand_rdy", r_act, exp_r);
      check("rand_q", q_act, prev_r | {NC{vte}});
      prev_r = exp_r;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
